// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath, with a memory watchdog.
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_ILLEGAL  = 4'd14,
    S_FAULT    = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          illegal_q, illegal_d;
  logic          bus_error_q, bus_error_d;
  logic          waiting;

  always_comb begin
    state_d     = state_q;
    wdog_d      = '0;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    waiting     = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);

    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b0110111:             state_d = S_LUI;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH:              state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FETCH;
    endcase

    // A mem_ready in the expiry cycle completes the access instead of faulting
    if (waiting && !mem_ready) begin
      if ((TIMEOUT != 0) && (wdog_q == CW'(TIMEOUT))) state_d = S_FAULT;
      else wdog_d = wdog_q + CW'(1);
    end

    if (state_d == S_ILLEGAL) illegal_d   = 1'b1;
    if (state_d == S_FAULT)   bus_error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wdog_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Outputs decode the registered state; only the fetch and store
  // completion strobes look at mem_ready. Everything is held low in reset.
  always_comb begin
    mem_req       = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCUpdate      = 1'b0;
    Branch        = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    instr_retired = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCUpdate  = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc     = 2'b01;
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req       = 1'b1;
          MemWrite      = 1'b1;
          AdrSrc        = 1'b1;
          instr_retired = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA       = 2'b10;
          ALUOp         = 2'b01;
          Branch        = 1'b1;
          instr_retired = 1'b1;
        end
        S_JAL: begin
          ALUSrcA  = 2'b01;
          ALUSrcB  = 2'b10;
          PCUpdate = 1'b1;
        end
        S_LUI: begin
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected state and
// control word are queued when stimulus is driven and compared on readback.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retired;
    logic       illegal;
    logic       bus_error;
  } ctrl_t;

  typedef struct {
    int    st;
    ctrl_t ctl;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_retired, illegal, bus_error;
  logic [3:0] state_dbg;
  ctrl_t      obs;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  multicycle_ctrl_fsm #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
    .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .instr_retired(instr_retired), .illegal(illegal), .bus_error(bus_error),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign obs = '{mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_retired, illegal, bus_error};

  // Expected control word for each state, straight from the state table
  function automatic ctrl_t ctrl_table(input int st, input bit rdy);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_req = 1; c.ir_write = rdy; c.pc_update = rdy;
                c.result_src = 2'b10; c.alu_src_b = 2'b10; end
      1:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      2:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      3:  begin c.mem_req = 1; c.adr_src = 1; end
      4:  begin c.result_src = 2'b01; c.reg_write = 1; c.retired = 1; end
      5:  begin c.mem_req = 1; c.mem_write = 1; c.adr_src = 1; c.retired = rdy; end
      6:  begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      7:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      8:  begin c.reg_write = 1; c.retired = 1; end
      9:  begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1; c.retired = 1; end
      10: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1; end
      11: begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      14: c.illegal = 1;
      15: c.bus_error = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Called on a falling edge; drives one cycle, checks it, returns on the next falling edge
  task automatic applyStimulus(input logic [6:0] op_v, input bit rdy,
                               input int exp_state, input string name);
    exp_t e;
    op        = op_v;
    mem_ready = rdy;
    sb.push_back('{st: exp_state, ctl: ctrl_table(exp_state, rdy), tag: name});
    #2;
    e = sb.pop_front();
    checkOutput({e.tag, " state"}, 32'(state_dbg), 32'(e.st));
    checkOutput({e.tag, " ctrl"}, 32'(obs), 32'(e.ctl));
    @(negedge clk);
  endtask

  task automatic doReset(input string name);
    reset     = 1'b1;
    mem_ready = 1'b1;
    op        = OP_R;
    #2;
    checkOutput({name, " reset state"}, 32'(state_dbg), 32'd0);
    checkOutput({name, " reset ctrl"}, 32'(obs), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    doReset("power-on");

    applyStimulus(OP_R, 1, 0, "R fetch");
    applyStimulus(OP_R, 1, 1, "R decode");
    applyStimulus(OP_R, 1, 6, "R execr");
    applyStimulus(OP_R, 1, 8, "R aluwb");

    applyStimulus(OP_LW, 1, 0, "lw fetch");
    applyStimulus(OP_LW, 0, 1, "lw decode");
    applyStimulus(OP_LW, 0, 2, "lw memadr");
    for (int i = 0; i < 3; i++) applyStimulus(OP_LW, 0, 3, "lw memread wait");
    applyStimulus(OP_LW, 1, 3, "lw memread done");
    applyStimulus(OP_LW, 0, 4, "lw memwb");

    applyStimulus(OP_SW, 1, 0, "sw fetch");
    applyStimulus(OP_SW, 0, 1, "sw decode");
    applyStimulus(OP_SW, 0, 2, "sw memadr");
    applyStimulus(OP_SW, 0, 5, "sw memwrite wait");
    applyStimulus(OP_SW, 1, 5, "sw memwrite done");

    applyStimulus(OP_BR, 1, 0, "br fetch");
    applyStimulus(OP_BR, 1, 1, "br decode");
    applyStimulus(OP_BR, 1, 9, "br branch");

    applyStimulus(OP_JAL, 1, 0, "jal fetch");
    applyStimulus(OP_JAL, 1, 1, "jal decode");
    applyStimulus(OP_JAL, 1, 10, "jal jal");
    applyStimulus(OP_JAL, 1, 8, "jal aluwb");

    applyStimulus(OP_LUI, 1, 0, "lui fetch");
    applyStimulus(OP_LUI, 1, 1, "lui decode");
    applyStimulus(OP_LUI, 1, 11, "lui lui");
    applyStimulus(OP_LUI, 1, 8, "lui aluwb");

    applyStimulus(OP_I, 1, 0, "addi fetch");
    applyStimulus(OP_I, 1, 1, "addi decode");
    applyStimulus(OP_I, 1, 7, "addi execi");
    applyStimulus(OP_I, 1, 8, "addi aluwb");

    applyStimulus(OP_SW, 1, 0, "abort fetch");
    applyStimulus(OP_SW, 0, 1, "abort decode");
    applyStimulus(OP_SW, 0, 2, "abort memadr");
    applyStimulus(OP_SW, 0, 5, "abort memwrite");
    doReset("mid-store");
    applyStimulus(OP_R, 0, 0, "post-abort fetch");
    applyStimulus(OP_R, 1, 0, "post-abort fetch done");

    applyStimulus(OP_SYS, 0, 1, "sys decode");
    for (int i = 0; i < 20; i++) applyStimulus(OP_SYS, 1, 14, "illegal hold");
    doReset("after illegal");
    applyStimulus(OP_R, 1, 0, "resume fetch");
    applyStimulus(OP_R, 1, 1, "resume decode");

    doReset("wdog expire");
    for (int i = 0; i < 17; i++) applyStimulus(OP_R, 0, 0, "wdog wait");
    for (int i = 0; i < 3; i++) applyStimulus(OP_R, 1, 15, "fault hold");

    doReset("wdog cycle16");
    for (int i = 0; i < 15; i++) applyStimulus(OP_R, 0, 0, "c16 wait");
    applyStimulus(OP_R, 1, 0, "c16 ready");
    applyStimulus(OP_R, 0, 1, "c16 decode");

    doReset("wdog cycle17");
    for (int i = 0; i < 16; i++) applyStimulus(OP_R, 0, 0, "c17 wait");
    applyStimulus(OP_R, 1, 0, "c17 ready at expiry");
    applyStimulus(OP_R, 0, 1, "c17 decode");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle RV32I core. It sequences the shared datapath through fetch, decode, execute, memory and writeback.
- It drives the datapath mux selects, the register, PC and IR write strobes, and the 2-bit ALUOp consumed by the existing ALU decoder.
- It handshakes with the unified instruction/data memory and traps on illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, 16, maximum cycles spent waiting for mem_ready before a bus fault; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  instr[6:0] from the IR.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  out  1  load the IR.
- PCUpdate  out  1  unconditional PC write.
- Branch  out  1  conditional PC write; the datapath ANDs it with Zero.
- RegWrite  out  1  register file write.
- MemWrite  out  1  memory write.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU operand A: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  ALU operand B: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- instr_retired  out  1  one-cycle pulse in an instruction's final cycle.
- illegal  out  1  sticky illegal-opcode flag.
- bus_error  out  1  sticky memory-timeout flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: state = FETCH, watchdog = 0, illegal = bus_error = 0.
  - While reset is high, every strobe and mem_req is forced to 0 and all selects are 00.
  - The first fetch request is issued in the first cycle after reset deasserts.
  - Reset mid-access abandons the access with no writes.
- Moore outputs: unlisted outputs are 0 in every state.
- FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite and PCUpdate are asserted only in the cycle mem_ready = 1; the FSM then moves to DECODE.
  - If mem_ready = 0, the FSM stays in FETCH.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other -> ILLEGAL
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Next: MEMREAD if op[5] = 0, MEMWRITE if op[5] = 1.
- MEMREAD: mem_req = 1, AdrSrc = 1, ResultSrc = 00. Waits for mem_ready, then -> MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, instr_retired = 1. Next: FETCH.
- MEMWRITE: mem_req = 1, MemWrite = 1, AdrSrc = 1, ResultSrc = 00, all held while waiting.
  - On mem_ready: instr_retired = 1, then -> FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Next: ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Next: ALUWB.
- LUI: ALUSrcA = 11, ALUSrcB = 01, ALUOp = 00. Next: ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, instr_retired = 1. Next: FETCH.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1, instr_retired = 1. Next: FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1. Next: ALUWB (writes PC+4 to rd).
- Latency with mem_ready tied to 1:
  - R/I/LUI/JAL/sw: 4 cycles.
  - lw: 5 cycles.
  - branch: 3 cycles.
- Watchdog:
  - Counts cycles with mem_req = 1 and mem_ready = 0; clears on mem_ready or on leaving a wait state.
  - When the count reaches TIMEOUT, the FSM goes to FAULT on the next edge and sets bus_error.
  - A mem_ready arriving on that same cycle wins: the access completes and no fault is raised.
- ILLEGAL / FAULT:
  - Terminal states with all strobes 0 and mem_req = 0.
  - illegal (respectively bus_error) stays 1 until reset.
- state_dbg encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7.
  - ALUWB = 8, BRANCH = 9, JAL = 10, LUI = 11, ILLEGAL = 14, FAULT = 15.

Test Plan:
- Reset, then op = 0110011 with mem_ready = 1 -> state_dbg sequence 0, 1, 6, 8, 0; RegWrite and instr_retired high only in the state-8 cycle; ALUOp = 10 in state 6.
- op = 0000011 with mem_ready delayed 3 cycles in MEMREAD -> states 0, 1, 2, 3, 3, 3, 3, 4, 0; mem_req held 4 cycles with AdrSrc = 1; RegWrite with ResultSrc = 01 in state 4.
- op = 1100011 -> states 0, 1, 9, 0; Branch = 1 and ALUOp = 01 exactly one cycle; PCUpdate asserted only in FETCH.
- op = 1101111 -> states 0, 1, 10, 8; PCUpdate = 1 in state 10; RegWrite in state 8. Then op = 0110111 -> state 11 with ALUSrcA = 11, ALUSrcB = 01.
- op = 1110011 -> state 14, illegal = 1, mem_req = 0 for 20 cycles; reset -> illegal = 0, fetch resumes.
- TIMEOUT = 16, mem_ready held 0 in FETCH -> IRWrite never asserted, state 15 after 17 cycles, bus_error = 1. Repeat with mem_ready pulsed on cycle 16 -> no fault, DECODE entered.
